// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared definitions for the multi-read-port register-file RAM:
//               clear/ready state encoding, byte-lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Widest word the lane-merge helper handles; callers cast to/from it.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    // Controller state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;
    typedef logic [MAX_BYTES-1:0]      wide_mask_t;

    // Number of byte lanes in a word of the given width
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Lane merge: new byte where mask bit is set, old byte elsewhere.
    // Shared by the array write path and the write-first bypass so both
    // always agree on the merged word.
    function automatic wide_word_t byte_merge(input wide_word_t old_word,
                                              input wide_word_t new_word,
                                              input wide_mask_t mask);
        wide_word_t merged;
        merged = old_word;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ram_clear_fsm
// Description : Post-reset clear sequencer. Walks every entry once, asserting
//               a clear write per cycle, then parks in ST_READY until the next
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic                   oBusy,
    output logic                   oClearWrite,
    output logic [INDEX_WIDTH-1:0] oClearAddress
);

    // One extra pointer bit so a full 2**ADDR_WIDTH array ends without wrap.
    localparam logic [ADDR_WIDTH:0] LAST_ENTRY = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);

    logic [0:0]          state;
    logic [ADDR_WIDTH:0] clear_ptr;

    // Sequencer: restart at entry 0 on every reset, advance one entry per cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clear_ptr <= clear_ptr + PTR_ONE;
            if (clear_ptr == LAST_ENTRY) begin
                state <= ST_READY;
            end
        end
    end

    // The reset cycle itself never writes the array.
    assign oBusy         = (state == ST_CLEAR);
    assign oClearWrite   = (state == ST_CLEAR) && !Reset;
    assign oClearAddress = clear_ptr[INDEX_WIDTH-1:0];

endmodule : ram_clear_fsm
`default_nettype wire

// File: rtl/ram_multi_read_port.sv
`default_nettype none
// ============================================================================
// Module      : ram_multi_read_port
// Description : Register-file RAM, one byte-masked write port and NUM_READ
//               registered read ports with enables, valid flags, range
//               checking, selectable write-first bypass and post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_multi_read_port
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    NUM_READ    = 2,
    parameter int                    BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH/8-1:0]        iWriteByteEn,
    input  logic [DATA_WIDTH-1:0]          iDataIn,
    input  logic [NUM_READ-1:0]            iReadEnable,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
    output logic [NUM_READ-1:0]            oValid,
    output logic [NUM_READ-1:0]            oReadError,
    output logic                           oWriteError,
    output logic                           oBusy
);

    localparam int BYTES       = bytes_of(DATA_WIDTH);
    localparam int INDEX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   busy;
    logic                   ready;
    logic                   clear_write;
    logic [INDEX_WIDTH-1:0] clear_index;

    logic                   write_in_range;
    logic                   write_fire;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [DATA_WIDTH-1:0]  write_old;
    logic [DATA_WIDTH-1:0]  write_merged;
    logic                   write_error;

    ram_clear_fsm #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_clear_fsm (
        .Clock        (Clock),
        .Reset        (Reset),
        .oBusy        (busy),
        .oClearWrite  (clear_write),
        .oClearAddress(clear_index)
    );

    assign ready = !busy;
    assign oBusy = busy;

    // Write decode; out-of-range writes are dropped and flagged.
    assign write_in_range = ({1'b0, iWriteAddress} < DEPTH_LIMIT);
    assign write_fire     = ready && iWriteEnable && write_in_range;
    assign write_index    = iWriteAddress[INDEX_WIDTH-1:0];
    assign write_old      = write_in_range ? mem[write_index] : '0;
    assign write_merged   = DATA_WIDTH'(byte_merge(wide_word_t'(write_old),
                                                   wide_word_t'(iDataIn),
                                                   wide_mask_t'(iWriteByteEn)));

    // Array update: clear sequencer owns the array while busy
    always_ff @(posedge Clock) begin
        if (clear_write) begin
            mem[clear_index] <= CLEAR_VALUE;
        end else if (write_fire) begin
            mem[write_index] <= write_merged;
        end
    end

    // One-cycle pulse for a dropped out-of-range write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            write_error <= 1'b0;
        end else begin
            write_error <= ready && iWriteEnable && !write_in_range;
        end
    end

    assign oWriteError = write_error;

    generate
        for (genvar k = 0; k < NUM_READ; k++) begin : g_read
            logic [ADDR_WIDTH-1:0]  rd_address;
            logic [INDEX_WIDTH-1:0] rd_index;
            logic                   rd_in_range;
            logic                   rd_collide;
            logic                   rd_fire;
            logic [DATA_WIDTH-1:0]  rd_word;
            logic [DATA_WIDTH-1:0]  rd_data_q;
            logic                   rd_valid_q;
            logic                   rd_error_q;

            assign rd_address  = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign rd_index    = rd_address[INDEX_WIDTH-1:0];
            assign rd_in_range = ({1'b0, rd_address} < DEPTH_LIMIT);
            assign rd_fire     = ready && iReadEnable[k];
            // Write-first: forward the merged word when hitting the live write
            assign rd_collide  = (BYPASS != 0) && write_fire &&
                                 (rd_address == iWriteAddress);
            assign rd_word     = !rd_in_range ? '0 :
                                 rd_collide   ? write_merged : mem[rd_index];

            // Read port register: data holds when idle, valid/error pulse
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                    rd_error_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_fire;
                    rd_error_q <= rd_fire && !rd_in_range;
                    if (rd_fire) begin
                        rd_data_q <= rd_word;
                    end
                end
            end

            assign oDataOut[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
            assign oValid[k]     = rd_valid_q;
            assign oReadError[k] = rd_error_q;
        end
    endgenerate

endmodule : ram_multi_read_port
`default_nettype wire

// File: tb/tb_ram_multi_read_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_multi_read_port
// Description : Scoreboard bench for ram_multi_read_port. Two instances share
//               stimulus: one write-first (BYPASS=1), one read-old (BYPASS=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_multi_read_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [7:0]  raddr;

    logic [63:0] dout_bp, dout_ro;
    logic [1:0]  valid_bp, valid_ro, rerr_bp, rerr_ro;
    logic        werr_bp, werr_ro, busy_bp, busy_ro;

    int          cyc = 0;
    logic        rst_q;
    int          n_cmp = 0;
    int          n_err = 0;

    // idx 0/1: bypass DUT port 0/1, idx 2/3: read-old DUT port 0/1,
    // idx 4/5: write-error pulse of bypass / read-old DUT
    typedef struct {
        int          stamp;
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];

    always #5 clk = ~clk;

    ram_multi_read_port #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(8), .NUM_READ(2),
        .BYPASS(1), .CLEAR_VALUE(32'h0)
    ) u_dut_bp (
        .Clock(clk), .Reset(rst), .iWriteEnable(we), .iWriteAddress(waddr),
        .iWriteByteEn(wbe), .iDataIn(wdata), .iReadEnable(ren),
        .iReadAddress(raddr), .oDataOut(dout_bp), .oValid(valid_bp),
        .oReadError(rerr_bp), .oWriteError(werr_bp), .oBusy(busy_bp)
    );

    ram_multi_read_port #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(8), .NUM_READ(2),
        .BYPASS(0), .CLEAR_VALUE(32'h0)
    ) u_dut_ro (
        .Clock(clk), .Reset(rst), .iWriteEnable(we), .iWriteAddress(waddr),
        .iWriteByteEn(wbe), .iDataIn(wdata), .iReadEnable(ren),
        .iReadAddress(raddr), .oDataOut(dout_ro), .oValid(valid_ro),
        .oReadError(rerr_ro), .oWriteError(werr_ro), .oBusy(busy_ro)
    );

    // Cycle stamp and the reset value the DUTs actually sampled
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s[%0d] cyc %0d: got %h expected %h",
                     name, idx, cyc, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected read result for port k, visible one edge after this cycle
    task automatic exp_rd(input int k, input logic [31:0] d_bp,
                          input logic [31:0] d_ro, input logic err);
        exp_t e;
        e.stamp = cyc + 1; e.idx = k;     e.data = d_bp; e.err = err;
        q.push_back(e);
        e.stamp = cyc + 1; e.idx = k + 2; e.data = d_ro; e.err = err;
        q.push_back(e);
    endtask

    task automatic exp_werr();
        exp_t e;
        e.stamp = cyc + 1; e.idx = 4; e.data = 32'h0; e.err = 1'b1;
        q.push_back(e);
        e.idx = 5;
        q.push_back(e);
    endtask

    // Hold user reads on while the clear runs; they must all be ignored
    task automatic wait_clear(input string name);
        int n;
        n   = 0;
        ren = 2'b11;
        raddr = 8'h21;
        while (busy_bp && n < 40) begin
            n++;
            step();
        end
        ren = 2'b00;
        chk(name, 0, 32'(n), 32'd8);
        chk("busy_ro_idle", 0, 32'(busy_ro), 32'd0);
    endtask

    // Monitor: pop expectations due this cycle and compare every output
    logic        ev [6];
    logic [31:0] ed [6];
    logic        ee [6];
    logic [31:0] last [4];
    logic [31:0] ad;
    logic        av, ae;
    exp_t        pe;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            ev[i] = 1'b0; ed[i] = 32'h0; ee[i] = 1'b0;
        end
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            pe = q.pop_front();
            if (pe.stamp == cyc) begin
                ev[pe.idx] = 1'b1; ed[pe.idx] = pe.data; ee[pe.idx] = pe.err;
            end
        end
        if (rst_q) begin
            for (int i = 0; i < 4; i++) last[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                ad = dout_bp[i*32 +: 32]; av = valid_bp[i]; ae = rerr_bp[i];
            end else begin
                ad = dout_ro[(i-2)*32 +: 32]; av = valid_ro[i-2]; ae = rerr_ro[i-2];
            end
            chk("valid", i, 32'(av), 32'(ev[i]));
            if (ev[i]) begin
                chk("data", i, ad, ed[i]);
                chk("rd_err", i, 32'(ae), 32'(ee[i]));
                last[i] = ed[i];
            end else begin
                chk("hold", i, ad, last[i]);
                chk("rd_err_idle", i, 32'(ae), 32'd0);
            end
        end
        chk("wr_err", 0, 32'(werr_bp), 32'(ev[4]));
        chk("wr_err", 1, 32'(werr_ro), 32'(ev[5]));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
        ren = '0; raddr = '0;
        step(); step();
        rst = 1'b0;

        // 1. clear lasts 8 cycles, then every entry reads 0
        wait_clear("busy_cycles");
        for (int a = 0; a < 8; a++) begin
            ren = 2'b11;
            raddr[3:0] = 4'(a);
            raddr[7:4] = 4'(7 - a);
            exp_rd(0, 32'h0, 32'h0, 1'b0);
            exp_rd(1, 32'h0, 32'h0, 1'b0);
            step();
        end
        ren = 2'b00;

        // 2. full write then masked overwrite
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wbe = 4'b1111;
        step();
        wdata = 32'h11223344; wbe = 4'b0101;
        step();
        we = 1'b0; ren = 2'b01; raddr[3:0] = 4'd3;
        exp_rd(0, 32'hDE22BE44, 32'hDE22BE44, 1'b0);
        step();

        // 3. collision: write-first vs read-old
        we = 1'b1; waddr = 4'd5; wdata = 32'hA5A5A5A5; wbe = 4'b1111;
        ren = 2'b10; raddr[7:4] = 4'd5;
        exp_rd(1, 32'hA5A5A5A5, 32'h00000000, 1'b0);
        step();
        we = 1'b0;
        exp_rd(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        step();
        // partial-mask collision, both ports on the same address
        we = 1'b1; waddr = 4'd3; wdata = 32'hFFFFFFFF; wbe = 4'b1000;
        ren = 2'b11; raddr = {4'd3, 4'd3};
        exp_rd(0, 32'hFF22BE44, 32'hDE22BE44, 1'b0);
        exp_rd(1, 32'hFF22BE44, 32'hDE22BE44, 1'b0);
        step();
        we = 1'b0;
        exp_rd(0, 32'hFF22BE44, 32'hFF22BE44, 1'b0);
        exp_rd(1, 32'hFF22BE44, 32'hFF22BE44, 1'b0);
        step();
        // all-zero mask: silent no-op
        we = 1'b1; waddr = 4'd3; wdata = 32'h0; wbe = 4'b0000; ren = 2'b00;
        step();
        we = 1'b0; ren = 2'b01; raddr[3:0] = 4'd3;
        exp_rd(0, 32'hFF22BE44, 32'hFF22BE44, 1'b0);
        step();

        // 4. out-of-range read and write
        ren = 2'b01; raddr[3:0] = 4'd9;
        we = 1'b1; waddr = 4'd12; wdata = 32'hCAFEF00D; wbe = 4'b1111;
        exp_rd(0, 32'h0, 32'h0, 1'b1);
        exp_werr();
        step();
        we = 1'b0; ren = 2'b11; raddr = {4'd7, 4'd4};
        exp_rd(0, 32'h0, 32'h0, 1'b0);
        exp_rd(1, 32'h0, 32'h0, 1'b0);
        step();
        // first invalid address 8 and top address 15
        we = 1'b1; waddr = 4'd8; wdata = 32'h55AA55AA; wbe = 4'b1111;
        raddr = {4'd8, 4'd15};
        exp_rd(0, 32'h0, 32'h0, 1'b1);
        exp_rd(1, 32'h0, 32'h0, 1'b1);
        exp_werr();
        step();
        // last valid address
        waddr = 4'd7; wdata = 32'h01020304; ren = 2'b00;
        step();
        we = 1'b0; ren = 2'b11; raddr = {4'd7, 4'd0};
        exp_rd(0, 32'h0, 32'h0, 1'b0);
        exp_rd(1, 32'h01020304, 32'h01020304, 1'b0);
        step();

        // 5. port 0 busy, port 1 idle and holding
        ren = 2'b01; raddr[3:0] = 4'd7;
        for (int i = 0; i < 3; i++) begin
            exp_rd(0, 32'h01020304, 32'h01020304, 1'b0);
            step();
        end
        ren = 2'b00;

        // 6. reset during clear restarts it from entry 0
        we = 1'b1; waddr = 4'd6; wdata = 32'h12345678; wbe = 4'b1111;
        step();
        we = 1'b0; ren = 2'b01; raddr[3:0] = 4'd6;
        exp_rd(0, 32'h12345678, 32'h12345678, 1'b0);
        step();
        ren = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("busy_mid_clear", i, 32'(busy_bp), 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_clear("busy_cycles_restart");
        ren = 2'b11; raddr = {4'd3, 4'd6};
        exp_rd(0, 32'h0, 32'h0, 1'b0);
        exp_rd(1, 32'h0, 32'h0, 1'b0);
        step();
        ren = 2'b00;
        step();
        step();

        chk("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_multi_read_port
`default_nettype wire

// File: doc/ram_multi_read_port.md
Name: ram_multi_read_port

Overview:
Parametrised register-file RAM with one write port and NUM_READ independent synchronous read ports. It adds per-port read enables and valid flags, byte-lane write enables, and a selectable write-first bypass on address collision. After every reset a built-in clear sequencer initialises all entries, and out-of-range accesses are flagged. It is the storage block for the datapath register bank, and it replaces the fixed two-port RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address bus width.
MEM_DEPTH, 256, number of entries; valid addresses are 0..MEM_DEPTH-1; MEM_DEPTH <= 2**ADDR_WIDTH.
NUM_READ, 2, number of read ports, 1..8.
BYPASS, 1, 1 = write-first on read/write collision, 0 = read-old.
CLEAR_VALUE, 0, word written to every entry by the clear sequence.

Ports:
Clock  in  1  single system clock; all logic is on the rising edge.
Reset  in  1  synchronous, active-high reset.
iWriteEnable  in  1  write request.
iWriteAddress  in  ADDR_WIDTH  write address.
iWriteByteEn  in  DATA_WIDTH/8  per-byte write mask; bit b covers bits [8b+7:8b].
iDataIn  in  DATA_WIDTH  write data.
iReadEnable  in  NUM_READ  per-port read request.
iReadAddress  in  NUM_READ*ADDR_WIDTH  port k address in slice [k*ADDR_WIDTH +: ADDR_WIDTH].
oDataOut  out  NUM_READ*DATA_WIDTH  port k data in slice [k*DATA_WIDTH +: DATA_WIDTH].
oValid  out  NUM_READ  oDataOut slice k updated this cycle.
oReadError  out  NUM_READ  port k read was out of range.
oWriteError  out  1  the write was out of range and was dropped.
oBusy  out  1  clear sequence in progress; all user requests are ignored.

Behaviour:
- Reset, sampled high on a Clock edge:
  - Registers: oDataOut=0, oValid=0, oReadError=0, oWriteError=0, oBusy=1, clear pointer=0, state=ST_CLEAR.
  - Reset asserted mid-clear restarts the clear at entry 0.
  - Memory contents are not touched in the reset cycle itself.
- State ST_CLEAR:
  - Each cycle with Reset low, write CLEAR_VALUE to Ram[ptr], then ptr<=ptr+1.
  - On the cycle that writes ptr==MEM_DEPTH-1, go to ST_READY. oBusy reads 0 from the next cycle.
  - Total oBusy time after Reset falls: exactly MEM_DEPTH cycles.
  - iWriteEnable and iReadEnable are ignored. oValid and both error outputs stay 0. oDataOut holds.
- State ST_READY writes:
  - iWriteEnable=1 and iWriteAddress<MEM_DEPTH: update only the byte lanes whose iWriteByteEn bit is 1; other lanes keep their old value.
  - All-zero byte mask: legal no-op with no error.
  - Address >= MEM_DEPTH: memory is unchanged and oWriteError=1 on the next cycle, a 1-cycle pulse.
- State ST_READY reads, independent per port k:
  - Latency is 1 cycle. If iReadEnable[k]=1 at edge N, then after edge N+1 oDataOut slice k holds the word, oValid[k]=1 and oReadError[k]=0.
  - If iReadEnable[k]=0: slice k holds its previous value and oValid[k]=0.
  - Read address >= MEM_DEPTH: slice k=0, oValid[k]=1, oReadError[k]=1 for one cycle.
  - Any number of ports may read the same address in the same cycle; all return identical data.
- Collision: read address equals a valid write address in the same cycle.
  - BYPASS=1: the read returns the post-write merged word, old bytes in masked-off lanes and new bytes elsewhere.
  - BYPASS=0: the read returns the pre-write word.
  - The written value is visible to all ports from the next cycle.
- ST_READY persists until the next Reset. There is no other path back to ST_CLEAR.
- Arithmetic: the clear pointer is ADDR_WIDTH+1 bits so that MEM_DEPTH=2**ADDR_WIDTH terminates without wrap. Address comparisons are unsigned.

Decomposition:
- Shared package ram_pkg:
  - state encoding ST_CLEAR=1'b0, ST_READY=1'b1;
  - function byte_merge(old, new, mask) returning the lane-merged word, used by both the write path and the bypass path;
  - constant BYTES = DATA_WIDTH/8 helper.
- Sub-module ram_clear_fsm: Clock, Reset, MEM_DEPTH parameter; outputs oBusy, clear write-enable and clear address.
- The top level muxes clear vs user write into the array and holds the NUM_READ read generate loop.

Test Plan (MEM_DEPTH=8, DATA_WIDTH=32, NUM_READ=2, ADDR_WIDTH=4, CLEAR_VALUE=0):
1. Reset high for 2 cycles, then low -> oBusy=1 for exactly 8 cycles, then 0. Reads of addresses 0..7 then return 0x00000000 with oValid=1. Reads issued while oBusy=1 give oValid=0.
2. Write 0xDEADBEEF to addr 3 with byte mask 4'b1111, then 0x11223344 to addr 3 with mask 4'b0101 -> port 0 read of addr 3 returns 0xDE22BE44 one cycle later.
3. Same cycle: write 0xA5A5A5A5 to addr 5 and port 1 reads addr 5, which holds 0x0. BYPASS=1 -> 0xA5A5A5A5; BYPASS=0 -> 0x00000000. The next-cycle read returns 0xA5A5A5A5 in both cases.
4. Port 0 reads addr 9 and a write goes to addr 12 -> next cycle: slice 0 =0, oValid[0]=1, oReadError[0]=1, oWriteError=1, all pulses 1 cycle. A following read of addr 4 is unchanged.
5. Port 0 read enabled and port 1 idle for 3 cycles -> oValid=2'b01 each cycle, and port 1 data holds its last value.
6. Reset asserted at clear cycle 4 -> oBusy stays 1 and a fresh 8-cycle clear follows Reset release. Any value written before that reset reads back 0.
